// File: rtl/dram_arbiter.sv
// dram_arbiter
// Round-robin arbiter and access sequencer sharing one single-port DRAM
// between four requesters. A winner is picked in IDLE and its access is
// driven for one cycle (ACCESS). Reads then wait out the DRAM read latency
// (WAIT), and every transaction ends with a one-cycle acknowledge (ACK).
//
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   req[3:0]            per-requester request, held until that requester's ack
//   we[3:0]             per-requester write (1) / read (0)
//   addr, wdata         flattened per-requester address / write data, slot i at [i*W +: W]
//   ack[3:0]            one-hot, one-cycle completion pulse
//   rdata               read data, valid in the ack cycle of a read, held otherwise
//   busy                high in ACCESS, WAIT and ACK
//   gnt_id              index of the current or most recent winner
//   mem_addr/we/wdata   DRAM port
//   mem_rdata           DRAM read data, valid RD_LAT cycles after the address
module dram_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [3:0]          req,
  input  logic [3:0]          we,
  input  logic [4*ADDR_W-1:0] addr,
  input  logic [4*DATA_W-1:0] wdata,
  output logic [3:0]          ack,
  output logic [DATA_W-1:0]   rdata,
  output logic                busy,
  output logic [1:0]          gnt_id,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_we,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int CNT_W = (RD_LAT < 2) ? 1 : $clog2(RD_LAT + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WAIT   = 2'd2,
    S_ACK    = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic [1:0]          r_last;
  logic                r_mask;
  logic [CNT_W-1:0]    r_cnt;
  logic [3:0]          r_ack;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_busy;
  logic [1:0]          r_gnt;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic                r_mem_we;
  logic [DATA_W-1:0]   r_mem_wdata;

  logic [3:0]          w_req_eff;
  logic                w_found;
  logic [1:0]          w_win;
  logic                w_grant;

  logic [1:0]          w_last_nxt;
  logic                w_mask_nxt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic [3:0]          w_ack_nxt;
  logic [DATA_W-1:0]   w_rdata_nxt;
  logic                w_busy_nxt;
  logic [1:0]          w_gnt_nxt;
  logic [ADDR_W-1:0]   w_mem_addr_nxt;
  logic                w_mem_we_nxt;
  logic [DATA_W-1:0]   w_mem_wdata_nxt;

  // Round-robin pick: scan from last+1 upward (mod 4); last itself is checked
  // last. Scanning in reverse lets the nearest requester overwrite the result.
  function automatic logic [2:0] rr_pick(input logic [3:0] reqs, input logic [1:0] last);
    logic [2:0] pick;
    logic [1:0] idx;
    pick = {1'b0, last};
    for (int k = 4; k >= 1; k--) begin
      idx = last + 2'(k);
      if (reqs[idx]) begin
        pick = {1'b1, idx};
      end else begin
        pick = pick;
      end
    end
    return pick;
  endfunction

  // Request masking and winner selection.
  always_comb begin
    w_req_eff = req;
    // The requester served in the previous ACK has not yet seen its ack
    // drop its req, so ignore it for exactly this one IDLE cycle.
    if (r_mask) begin
      w_req_eff[r_last] = 1'b0;
    end else begin
      w_req_eff = req;
    end
    {w_found, w_win} = rr_pick(w_req_eff, r_last);
    w_grant = (r_state == S_IDLE) && w_found;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_state_nxt = S_ACCESS;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_ACCESS: begin
        // mem_we is registered and high only in ACCESS for a write.
        if (r_mem_we) begin
          w_state_nxt = S_ACK;
        end else begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (r_cnt == CNT_W'(1)) begin
          w_state_nxt = S_ACK;
        end else begin
          w_state_nxt = S_WAIT;
        end
      end
      S_ACK: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Output logic: next values of every registered output and datapath register.
  always_comb begin
    w_last_nxt      = r_last;
    w_gnt_nxt       = r_gnt;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_wdata_nxt = r_mem_wdata;
    w_mem_we_nxt    = 1'b0;
    w_cnt_nxt       = r_cnt;
    w_rdata_nxt     = r_rdata;

    if (w_grant) begin
      w_last_nxt      = w_win;
      w_gnt_nxt       = w_win;
      w_mem_addr_nxt  = addr[w_win*ADDR_W +: ADDR_W];
      w_mem_wdata_nxt = wdata[w_win*DATA_W +: DATA_W];
      w_mem_we_nxt    = we[w_win];
    end else begin
      w_mem_we_nxt    = 1'b0;
    end

    case (r_state)
      S_ACCESS: begin
        w_cnt_nxt = CNT_W'(RD_LAT);
      end
      S_WAIT: begin
        w_cnt_nxt = r_cnt - CNT_W'(1);
        // Last WAIT cycle: mem_rdata is valid now.
        if (r_cnt == CNT_W'(1)) begin
          w_rdata_nxt = mem_rdata;
        end else begin
          w_rdata_nxt = r_rdata;
        end
      end
      default: begin
        w_cnt_nxt = r_cnt;
      end
    endcase

    if (w_state_nxt == S_ACK) begin
      w_ack_nxt = 4'b0001 << r_gnt;
    end else begin
      w_ack_nxt = 4'b0000;
    end

    w_busy_nxt = (w_state_nxt != S_IDLE);
    w_mask_nxt = (r_state == S_ACK);
  end

  // Output and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last      <= 2'd3;
      r_mask      <= 1'b0;
      r_cnt       <= '0;
      r_ack       <= 4'b0000;
      r_rdata     <= '0;
      r_busy      <= 1'b0;
      r_gnt       <= 2'd0;
      r_mem_addr  <= '0;
      r_mem_we    <= 1'b0;
      r_mem_wdata <= '0;
    end else begin
      r_last      <= w_last_nxt;
      r_mask      <= w_mask_nxt;
      r_cnt       <= w_cnt_nxt;
      r_ack       <= w_ack_nxt;
      r_rdata     <= w_rdata_nxt;
      r_busy      <= w_busy_nxt;
      r_gnt       <= w_gnt_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_we    <= w_mem_we_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
    end
  end

  assign ack       = r_ack;
  assign rdata     = r_rdata;
  assign busy      = r_busy;
  assign gnt_id    = r_gnt;
  assign mem_addr  = r_mem_addr;
  assign mem_we    = r_mem_we;
  assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_dram_arbiter.sv
// Self-checking bench for dram_arbiter. Expected acks are pushed to a
// scoreboard when a request is driven and popped when the DUT pulses ack.
// Cycle k of a scenario is observed at the falling edge k cycles after the
// falling edge where the request was driven (cycle 0).
module tb_dram_arbiter;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;
  localparam int RD_LAT = 2;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [3:0]          req = 4'b0000;
  logic [3:0]          we = 4'b0000;
  logic [4*ADDR_W-1:0] addr = '0;
  logic [4*DATA_W-1:0] wdata = '0;
  logic [3:0]          ack;
  logic [DATA_W-1:0]   rdata;
  logic                busy;
  logic [1:0]          gnt_id;
  logic [ADDR_W-1:0]   mem_addr;
  logic                mem_we;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W-1:0]   mem_rdata;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;

  typedef struct {
    logic [3:0] ack;
    logic [1:0] gnt;
    logic       chk_rd;
    logic [7:0] rd;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  dram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .ack(ack), .rdata(rdata), .busy(busy), .gnt_id(gnt_id),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // DRAM model: data appears RD_LAT (=2) cycles after the address.
  logic [7:0] dmem [256];
  logic [7:0] rp0 = 8'h00;
  logic [7:0] rp1 = 8'h00;
  always @(posedge clk) begin
    if (mem_we) dmem[mem_addr] <= mem_wdata;
    rp0 <= dmem[mem_addr];
    rp1 <= rp0;
  end
  assign mem_rdata = rp1;

  task automatic set_req(input int id, input logic w, input logic [7:0] a, input logic [7:0] d);
    req[id] = 1'b1;
    we[id] = w;
    addr[id*ADDR_W +: ADDR_W] = a;
    wdata[id*DATA_W +: DATA_W] = d;
  endtask

  task automatic push_exp(input logic [3:0] a, input logic [1:0] g, input logic c,
                          input logic [7:0] d, input int t);
    exp_t x;
    x.ack = a; x.gnt = g; x.chk_rd = c; x.rd = d; x.cyc = t;
    sb.push_back(x);
  endtask

  task automatic apply_reset();
    rst = 1'b1; req = 4'b0000; we = 4'b0000;
    sb.delete();
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 4'b0000;
    @(negedge clk); @(negedge clk);
    n_checks++; if (ack !== 4'b0000) begin n_fail++; $display("FAIL reset_ack: got %b, required 0000", ack); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, required 0", busy); end
    n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem_we: got %b, required 0", mem_we); end
    n_checks++; if (gnt_id !== 2'd0) begin n_fail++; $display("FAIL reset_gnt_id: got %0d, required 0", gnt_id); end
    n_checks++; if ({rdata, mem_addr, mem_wdata} !== 24'h000000) begin
      n_fail++; $display("FAIL reset_data: got rdata=%h mem_addr=%h mem_wdata=%h, required all 00", rdata, mem_addr, mem_wdata);
    end
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0 || ack !== 4'b0000) begin
      n_fail++; $display("FAIL reset_idle: got busy=%b ack=%b, required 0 and 0000", busy, ack);
    end
  endtask

  task automatic test_single_write();
    int t0;
    @(negedge clk);
    set_req(2, 1'b1, 8'h05, 8'hA5); t0 = cyc;
    push_exp(4'b0100, 2'd2, 1'b0, 8'h00, t0 + 2);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 1) begin
        n_checks++; if (mem_we !== 1'b1 || mem_addr !== 8'h05 || mem_wdata !== 8'hA5 || busy !== 1'b1) begin
          n_fail++; $display("FAIL write_port: got we=%b addr=%h wdata=%h busy=%b, required 1 05 A5 1", mem_we, mem_addr, mem_wdata, busy);
        end
      end
      if (k >= 2) begin
        n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL write_we_low: cycle %0d got %b, required 0", k, mem_we); end
      end
      if (ack !== 4'b0000) begin
        n_checks++;
        if (sb.size() == 0) begin n_fail++; $display("FAIL write_ack_extra: got ack=%b at cycle %0d, required none", ack, cyc); end
        else begin
          e = sb.pop_front();
          if (ack !== e.ack || gnt_id !== e.gnt || cyc !== e.cyc) begin
            n_fail++; $display("FAIL write_ack: got ack=%b gnt=%0d cyc=%0d, required ack=%b gnt=%0d cyc=%0d", ack, gnt_id, cyc, e.ack, e.gnt, e.cyc);
          end
        end
      end
      if (k == 2) req[2] = 1'b0;
    end
    n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL write_ack_missing: got %0d outstanding, required 0", sb.size()); sb.delete(); end
  endtask

  task automatic test_single_read();
    int t0;
    @(negedge clk);
    set_req(1, 1'b0, 8'h05, 8'h00); t0 = cyc;
    push_exp(4'b0010, 2'd1, 1'b1, 8'hA5, t0 + 4);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k == 1) begin
        n_checks++; if (mem_addr !== 8'h05) begin n_fail++; $display("FAIL read_addr: got %h, required 05", mem_addr); end
      end
      n_checks++;
      if (busy !== (k <= 4) || mem_we !== 1'b0) begin
        n_fail++; $display("FAIL read_busy: cycle %0d got busy=%b we=%b, required busy=%b we=0", k, busy, mem_we, (k <= 4));
      end
      if (ack !== 4'b0000) begin
        n_checks++;
        if (sb.size() == 0) begin n_fail++; $display("FAIL read_ack_extra: got ack=%b at cycle %0d, required none", ack, cyc); end
        else begin
          e = sb.pop_front();
          if (ack !== e.ack || gnt_id !== e.gnt || cyc !== e.cyc || rdata !== e.rd) begin
            n_fail++; $display("FAIL read_ack: got ack=%b gnt=%0d cyc=%0d rdata=%h, required ack=%b gnt=%0d cyc=%0d rdata=%h", ack, gnt_id, cyc, rdata, e.ack, e.gnt, e.cyc, e.rd);
          end
        end
      end
      if (k == 4) req[1] = 1'b0;
    end
    n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL read_ack_missing: got %0d outstanding, required 0", sb.size()); sb.delete(); end

    // A write must leave rdata holding the last read value.
    @(negedge clk);
    set_req(0, 1'b1, 8'h10, 8'h77); t0 = cyc;
    push_exp(4'b0001, 2'd0, 1'b1, 8'hA5, t0 + 2);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (ack !== 4'b0000) begin
        n_checks++;
        if (sb.size() == 0) begin n_fail++; $display("FAIL hold_ack_extra: got ack=%b at cycle %0d, required none", ack, cyc); end
        else begin
          e = sb.pop_front();
          if (ack !== e.ack || gnt_id !== e.gnt || cyc !== e.cyc || rdata !== e.rd) begin
            n_fail++; $display("FAIL hold_ack: got ack=%b gnt=%0d cyc=%0d rdata=%h, required ack=%b gnt=%0d cyc=%0d rdata=%h", ack, gnt_id, cyc, rdata, e.ack, e.gnt, e.cyc, e.rd);
          end
        end
      end
      if (k == 2) req[0] = 1'b0;
    end
    n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL hold_ack_missing: got %0d outstanding, required 0", sb.size()); sb.delete(); end
  endtask

  task automatic test_reset_mid_read();
    int t0;
    @(negedge clk);
    set_req(2, 1'b0, 8'h30, 8'h00);
    @(negedge clk);   // cycle 1: ACCESS
    @(negedge clk);   // cycle 2: WAIT
    rst = 1'b1;
    #1;
    n_checks++; if (mem_we !== 1'b0 || busy !== 1'b0 || ack !== 4'b0000) begin
      n_fail++; $display("FAIL midrst_ctrl: got we=%b busy=%b ack=%b, required 0 0 0000", mem_we, busy, ack);
    end
    n_checks++; if (rdata !== 8'h00 || gnt_id !== 2'd0 || mem_addr !== 8'h00) begin
      n_fail++; $display("FAIL midrst_regs: got rdata=%h gnt=%0d addr=%h, required 00 0 00", rdata, gnt_id, mem_addr);
    end
    req = 4'b0000;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      n_checks++; if (ack !== 4'b0000 || busy !== 1'b0) begin
        n_fail++; $display("FAIL midrst_no_ack: got ack=%b busy=%b, required 0000 0", ack, busy);
      end
    end
    // Requester 0 must win over requester 3 right after reset.
    @(negedge clk);
    set_req(3, 1'b1, 8'h20, 8'h33);
    set_req(0, 1'b1, 8'h21, 8'h44); t0 = cyc;
    push_exp(4'b0001, 2'd0, 1'b0, 8'h00, t0 + 2);
    push_exp(4'b1000, 2'd3, 1'b0, 8'h00, t0 + 5);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (ack !== 4'b0000) begin
        n_checks++;
        if (sb.size() == 0) begin n_fail++; $display("FAIL prio_ack_extra: got ack=%b at cycle %0d, required none", ack, cyc); end
        else begin
          e = sb.pop_front();
          if (ack !== e.ack || gnt_id !== e.gnt || cyc !== e.cyc) begin
            n_fail++; $display("FAIL prio_ack: got ack=%b gnt=%0d cyc=%0d, required ack=%b gnt=%0d cyc=%0d", ack, gnt_id, cyc, e.ack, e.gnt, e.cyc);
          end
        end
      end
      if (k == 2) req[0] = 1'b0;
      if (k == 5) req[3] = 1'b0;
    end
    n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL prio_ack_missing: got %0d outstanding, required 0", sb.size()); sb.delete(); end
  endtask

  task automatic test_drop_after_grant();
    int t0;
    @(negedge clk);
    set_req(1, 1'b1, 8'h40, 8'h3C); t0 = cyc;
    push_exp(4'b0010, 2'd1, 1'b0, 8'h00, t0 + 2);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 1) begin
        n_checks++; if (mem_we !== 1'b1 || mem_addr !== 8'h40 || mem_wdata !== 8'h3C) begin
          n_fail++; $display("FAIL drop_port: got we=%b addr=%h wdata=%h, required 1 40 3C", mem_we, mem_addr, mem_wdata);
        end
        req[1] = 1'b0;
      end
      if (ack !== 4'b0000) begin
        n_checks++;
        if (sb.size() == 0) begin n_fail++; $display("FAIL drop_ack_extra: got ack=%b at cycle %0d, required none", ack, cyc); end
        else begin
          e = sb.pop_front();
          if (ack !== e.ack || gnt_id !== e.gnt || cyc !== e.cyc) begin
            n_fail++; $display("FAIL drop_ack: got ack=%b gnt=%0d cyc=%0d, required ack=%b gnt=%0d cyc=%0d", ack, gnt_id, cyc, e.ack, e.gnt, e.cyc);
          end
        end
      end
    end
    n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL drop_ack_missing: got %0d outstanding, required 0", sb.size()); sb.delete(); end
    // Read the location back to confirm the write landed in DRAM.
    @(negedge clk);
    set_req(1, 1'b0, 8'h40, 8'h00); t0 = cyc;
    push_exp(4'b0010, 2'd1, 1'b1, 8'h3C, t0 + 4);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (ack !== 4'b0000) begin
        n_checks++;
        if (sb.size() == 0) begin n_fail++; $display("FAIL dropchk_ack_extra: got ack=%b at cycle %0d, required none", ack, cyc); end
        else begin
          e = sb.pop_front();
          if (ack !== e.ack || gnt_id !== e.gnt || cyc !== e.cyc || rdata !== e.rd) begin
            n_fail++; $display("FAIL dropchk_ack: got ack=%b cyc=%0d rdata=%h, required ack=%b cyc=%0d rdata=%h", ack, cyc, rdata, e.ack, e.cyc, e.rd);
          end
        end
      end
      if (k == 4) req[1] = 1'b0;
    end
    n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL dropchk_ack_missing: got %0d outstanding, required 0", sb.size()); sb.delete(); end
  endtask

  task automatic test_fairness();
    int t0;
    apply_reset();
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, 8'(8'h60 + i), 8'(8'hC0 + i));
    t0 = cyc;
    for (int j = 0; j < 5; j++) push_exp(4'b0001 << (j % 4), 2'(j % 4), 1'b0, 8'h00, t0 + 2 + 3*j);
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk);
      if (k % 3 == 0 && k <= 12) begin
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL fair_idle_gap: cycle %0d got busy=%b, required 0", k, busy); end
      end
      if (ack !== 4'b0000) begin
        n_checks++;
        if (sb.size() == 0) begin n_fail++; $display("FAIL fair_ack_extra: got ack=%b at cycle %0d, required none", ack, cyc); end
        else begin
          e = sb.pop_front();
          if (ack !== e.ack || gnt_id !== e.gnt || cyc !== e.cyc) begin
            n_fail++; $display("FAIL fair_ack: got ack=%b gnt=%0d cyc=%0d, required ack=%b gnt=%0d cyc=%0d", ack, gnt_id, cyc, e.ack, e.gnt, e.cyc);
          end
        end
      end
      if (k == 14) req = 4'b0000;
    end
    n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL fair_ack_missing: got %0d outstanding, required 0", sb.size()); sb.delete(); end
  endtask

  task automatic test_continuous_single();
    int t0;
    apply_reset();
    set_req(3, 1'b1, 8'h50, 8'h99); t0 = cyc;
    push_exp(4'b1000, 2'd3, 1'b0, 8'h00, t0 + 2);
    push_exp(4'b1000, 2'd3, 1'b0, 8'h00, t0 + 6);
    push_exp(4'b1000, 2'd3, 1'b0, 8'h00, t0 + 10);
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (k == 3 || k == 4) begin
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL cont_mask: cycle %0d got busy=%b, required 0", k, busy); end
      end
      if (k == 5) begin
        n_checks++; if (busy !== 1'b1 || mem_we !== 1'b1) begin
          n_fail++; $display("FAIL cont_regrant: got busy=%b we=%b, required 1 1", busy, mem_we);
        end
      end
      if (ack !== 4'b0000) begin
        n_checks++;
        if (sb.size() == 0) begin n_fail++; $display("FAIL cont_ack_extra: got ack=%b at cycle %0d, required none", ack, cyc); end
        else begin
          e = sb.pop_front();
          if (ack !== e.ack || gnt_id !== e.gnt || cyc !== e.cyc) begin
            n_fail++; $display("FAIL cont_ack: got ack=%b gnt=%0d cyc=%0d, required ack=%b gnt=%0d cyc=%0d", ack, gnt_id, cyc, e.ack, e.gnt, e.cyc);
          end
        end
      end
      if (k == 10) req[3] = 1'b0;
    end
    n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL cont_ack_missing: got %0d outstanding, required 0", sb.size()); sb.delete(); end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_single_read();
    test_reset_mid_read();
    test_drop_after_grant();
    test_fairness();
    test_continuous_single();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
